// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Requester 0 is the execute stage and requester 1 is the auxiliary/AGU path.
// The block arbitrates round-robin, drives the ALU for a single cycle,
// captures the result, and holds it until the granted requester consumes it.
// Opcodes the ALU does not implement skip the ALU and return an error response.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_opcode,
  input  logic [1:0]  req_ar_flag,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [15:0] rsp_dst,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] op_count,
  output logic [3:0]  alu_opcode,
  output logic        alu_ar_flag,
  output logic [15:0] alu_src1,
  output logic [15:0] alu_src2,
  input  logic [15:0] alu_dst,
  input  logic [3:0]  alu_flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_lastGrant;
  logic        r_grant;
  logic [3:0]  r_aluOpcode;
  logic        r_aluArFlag;
  logic [15:0] r_aluSrc1;
  logic [15:0] r_aluSrc2;
  logic [1:0]  r_rspValid;
  logic [15:0] r_rspDst;
  logic [3:0]  r_rspFlags;
  logic        r_rspErr;
  logic        r_busy;
  logic [15:0] r_opCount;

  logic        w_accept;
  logic        w_grant;
  logic [3:0]  w_selOpcode;
  logic        w_selArFlag;
  logic [15:0] w_selSrc1;
  logic [15:0] w_selSrc2;
  logic        w_supported;
  logic        w_rspDone;

  // Pick the winner: a lone requester wins outright, a tie goes to whoever was not served last.
  always_comb begin
    w_grant     = (req_valid == 2'b11) ? ~r_lastGrant : req_valid[1];
    w_accept    = (r_state == IDLE) && (req_valid != 2'b00);
    w_selOpcode = w_grant ? req_opcode[7:4]  : req_opcode[3:0];
    w_selArFlag = w_grant ? req_ar_flag[1]   : req_ar_flag[0];
    w_selSrc1   = w_grant ? req_src1[31:16]  : req_src1[15:0];
    w_selSrc2   = w_grant ? req_src2[31:16]  : req_src2[15:0];
    w_supported = (w_selOpcode >= 4'd3) && (w_selOpcode <= 4'd9);
    w_rspDone   = (r_state == RESP) && rsp_ready[r_grant];
    req_ready   = w_accept ? {w_grant, ~w_grant} : 2'b00;
  end

  // Main FSM: grant in IDLE, run the ALU for one cycle in EXEC, hold the result in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lastGrant <= 1'b1;
      r_grant     <= 1'b0;
      r_aluOpcode <= 4'd0;
      r_aluArFlag <= 1'b0;
      r_aluSrc1   <= 16'd0;
      r_aluSrc2   <= 16'd0;
      r_rspValid  <= 2'b00;
      r_rspDst    <= 16'd0;
      r_rspFlags  <= 4'd0;
      r_rspErr    <= 1'b0;
      r_busy      <= 1'b0;
      r_opCount   <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_grant     <= w_grant;
            r_lastGrant <= w_grant;
            r_busy      <= 1'b1;
            if (w_supported) begin
              r_state     <= EXEC;
              r_aluOpcode <= w_selOpcode;
              r_aluArFlag <= w_selArFlag;
              r_aluSrc1   <= w_selSrc1;
              r_aluSrc2   <= w_selSrc2;
            end else begin
              r_state    <= RESP;
              r_rspValid <= {w_grant, ~w_grant};
              r_rspDst   <= 16'd0;
              r_rspFlags <= 4'd0;
              r_rspErr   <= 1'b1;
            end
          end
        end
        EXEC: begin
          r_state     <= RESP;
          r_rspDst    <= alu_dst;
          r_rspFlags  <= alu_flags;
          r_rspErr    <= 1'b0;
          r_rspValid  <= {r_grant, ~r_grant};
          r_aluOpcode <= 4'd0;
          r_aluArFlag <= 1'b0;
          r_aluSrc1   <= 16'd0;
          r_aluSrc2   <= 16'd0;
        end
        RESP: begin
          if (w_rspDone) begin
            r_state    <= IDLE;
            r_rspValid <= 2'b00;
            r_busy     <= 1'b0;
            if (!r_rspErr) begin
              r_opCount <= r_opCount + 16'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid   = r_rspValid;
  assign rsp_dst     = r_rspDst;
  assign rsp_flags   = r_rspFlags;
  assign rsp_err     = r_rspErr;
  assign busy        = r_busy;
  assign op_count    = r_opCount;
  assign alu_opcode  = r_aluOpcode;
  assign alu_ar_flag = r_aluArFlag;
  assign alu_src1    = r_aluSrc1;
  assign alu_src2    = r_aluSrc2;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed, table-driven bench for alu_arbiter with a small
// stand-in ALU so results can be predicted by hand.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_opcode;
  logic [1:0]  req_ar_flag;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_dst;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic        busy;
  logic [15:0] op_count;
  logic [3:0]  alu_opcode;
  logic        alu_ar_flag;
  logic [15:0] alu_src1;
  logic [15:0] alu_src2;
  logic [15:0] alu_dst;
  logic [3:0]  alu_flags;

  int checks;
  int errors;
  logic [15:0] expCount;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_ar_flag(req_ar_flag),
    .req_src1(req_src1), .req_src2(req_src2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dst(rsp_dst), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count),
    .alu_opcode(alu_opcode), .alu_ar_flag(alu_ar_flag),
    .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_dst(alu_dst), .alu_flags(alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: flags are {zero, negative, ar_flag, 0} so expected values stay hand-computable.
  always_comb begin
    alu_dst = 16'd0;
    case (alu_opcode)
      4'd3: alu_dst = alu_src1 + alu_src2;
      4'd4: alu_dst = alu_src1 - alu_src2;
      4'd5: alu_dst = alu_src1 * alu_src2;
      4'd6: alu_dst = (alu_src2 == 16'd0) ? 16'hFFFF : alu_src1 / alu_src2;
      4'd7: alu_dst = alu_src1 & alu_src2;
      4'd8: alu_dst = alu_src1 | alu_src2;
      4'd9: alu_dst = alu_src1 ^ alu_src2;
      default: alu_dst = 16'd0;
    endcase
    alu_flags = {(alu_dst == 16'd0), alu_dst[15], alu_ar_flag, 1'b0};
  end

  typedef struct {
    logic [1:0]  valid;
    logic [7:0]  opc;
    logic [1:0]  ar;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        g;
    logic [15:0] dst;
    logic [3:0]  flags;
    logic        err;
  } vec_t;

  vec_t vecs [11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [7:0] opc, input logic [1:0] ar,
                               input logic [31:0] s1, input logic [31:0] s2);
    req_valid   = valid;
    req_opcode  = opc;
    req_ar_flag = ar;
    req_src1    = s1;
    req_src2    = s2;
  endtask

  // Runs one complete transaction at minimum latency, checking every stage.
  task automatic runVector(input vec_t v);
    logic [3:0]  gOp;
    logic [15:0] gS1;
    logic [1:0]  oneHot;
    gOp    = v.g ? v.opc[7:4] : v.opc[3:0];
    gS1    = v.g ? v.s1[31:16] : v.s1[15:0];
    oneHot = v.g ? 2'b10 : 2'b01;
    @(negedge clk);
    applyStimulus(v.valid, v.opc, v.ar, v.s1, v.s2);
    #1;
    checkOutput("req_ready grant", {30'd0, req_ready}, {30'd0, oneHot});
    @(posedge clk);
    @(negedge clk);
    applyStimulus(2'b00, 8'd0, 2'b00, 32'd0, 32'd0);
    checkOutput("busy after accept", {31'd0, busy}, 32'd1);
    if (!v.err) begin
      checkOutput("alu_opcode in EXEC", {28'd0, alu_opcode}, {28'd0, gOp});
      checkOutput("alu_src1 in EXEC", {16'd0, alu_src1}, {16'd0, gS1});
      checkOutput("rsp_valid in EXEC", {30'd0, rsp_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("rsp_valid", {30'd0, rsp_valid}, {30'd0, oneHot});
    checkOutput("rsp_dst", {16'd0, rsp_dst}, {16'd0, v.dst});
    checkOutput("rsp_flags", {28'd0, rsp_flags}, {28'd0, v.flags});
    checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, v.err});
    checkOutput("alu_opcode in RESP", {28'd0, alu_opcode}, 32'd0);
    rsp_ready = oneHot;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
    if (!v.err) expCount = expCount + 16'd1;
    checkOutput("rsp_valid after handshake", {30'd0, rsp_valid}, 32'd0);
    checkOutput("busy after handshake", {31'd0, busy}, 32'd0);
    checkOutput("op_count", {16'd0, op_count}, {16'd0, expCount});
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    expCount = 16'd0;
    reset    = 1'b1;
    rsp_ready = 2'b00;
    applyStimulus(2'b00, 8'd0, 2'b00, 32'd0, 32'd0);

    vecs[0]  = '{2'b11, {4'h7, 4'h4}, 2'b00, {16'd10, 16'd10}, {16'd5, 16'd5}, 1'b0, 16'd5, 4'h0, 1'b0};
    vecs[1]  = '{2'b11, {4'h7, 4'h4}, 2'b00, {16'd10, 16'd10}, {16'd5, 16'd5}, 1'b1, 16'd0, 4'h8, 1'b0};
    vecs[2]  = '{2'b11, {4'h8, 4'h3}, 2'b00, {16'd10, 16'd10}, {16'd5, 16'd5}, 1'b0, 16'd15, 4'h0, 1'b0};
    vecs[3]  = '{2'b10, {4'h5, 4'h0}, 2'b10, {16'd300, 16'd0}, {16'd200, 16'd0}, 1'b1, 16'hEA60, 4'h6, 1'b0};
    vecs[4]  = '{2'b10, {4'hF, 4'h0}, 2'b00, {16'd10, 16'd0}, {16'd5, 16'd0}, 1'b1, 16'd0, 4'h0, 1'b1};
    vecs[5]  = '{2'b01, {4'h0, 4'h0}, 2'b00, {16'd0, 16'd10}, {16'd0, 16'd5}, 1'b0, 16'd0, 4'h0, 1'b1};
    vecs[6]  = '{2'b01, {4'h0, 4'h6}, 2'b01, {16'd0, 16'd100}, {16'd0, 16'd7}, 1'b0, 16'd14, 4'h2, 1'b0};
    vecs[7]  = '{2'b01, {4'h0, 4'h9}, 2'b00, {16'd0, 16'd10}, {16'd0, 16'd5}, 1'b0, 16'd15, 4'h0, 1'b0};
    vecs[8]  = '{2'b10, {4'h8, 4'h0}, 2'b00, {16'h8000, 16'd0}, {16'h0001, 16'd0}, 1'b1, 16'h8001, 4'h4, 1'b0};
    vecs[9]  = '{2'b01, {4'h0, 4'hA}, 2'b00, {16'd0, 16'd3}, {16'd0, 16'd4}, 1'b0, 16'd0, 4'h0, 1'b1};
    vecs[10] = '{2'b01, {4'h0, 4'h2}, 2'b00, {16'd0, 16'd3}, {16'd0, 16'd4}, 1'b0, 16'd0, 4'h0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset req_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("reset rsp_valid", {30'd0, rsp_valid}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset op_count", {16'd0, op_count}, 32'd0);
    checkOutput("reset alu_opcode", {28'd0, alu_opcode}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      runVector(vecs[i]);
    end

    // Backpressure on r0 while r1 waits, including a stray rsp_ready from r1
    @(negedge clk);
    applyStimulus(2'b01, {4'h3, 4'h9}, 2'b00, {16'd1, 16'd10}, {16'd2, 16'd5});
    #1;
    checkOutput("bp req_ready r0", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    checkOutput("bp req_ready in EXEC", {30'd0, req_ready}, 32'd0);
    checkOutput("bp alu_opcode", {28'd0, alu_opcode}, 32'd9);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rsp_ready = (c == 1) ? 2'b10 : 2'b00;
      #1;
      checkOutput("bp rsp_valid held", {30'd0, rsp_valid}, 32'd1);
      checkOutput("bp rsp_dst held", {16'd0, rsp_dst}, 32'd15);
      checkOutput("bp rsp_flags held", {28'd0, rsp_flags}, 32'd0);
      checkOutput("bp req_ready held", {30'd0, req_ready}, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    rsp_ready = 2'b01;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
    expCount = expCount + 16'd1;
    #1;
    checkOutput("bp r1 granted after handshake", {30'd0, req_ready}, 32'd2);
    checkOutput("bp op_count", {16'd0, op_count}, {16'd0, expCount});
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp r1 rsp_valid", {30'd0, rsp_valid}, 32'd2);
    checkOutput("bp r1 rsp_dst", {16'd0, rsp_dst}, 32'd3);
    rsp_ready = 2'b10;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
    expCount = expCount + 16'd1;
    checkOutput("bp r1 op_count", {16'd0, op_count}, {16'd0, expCount});

    // Reset in the middle of EXEC drops the operation
    @(negedge clk);
    applyStimulus(2'b01, {4'h0, 4'h5}, 2'b00, {16'd0, 16'd10}, {16'd0, 16'd5});
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    checkOutput("rst alu_opcode mul", {28'd0, alu_opcode}, 32'd5);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    expCount = 16'd0;
    checkOutput("rst rsp_valid", {30'd0, rsp_valid}, 32'd0);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst alu_opcode", {28'd0, alu_opcode}, 32'd0);
    checkOutput("rst alu_src1", {16'd0, alu_src1}, 32'd0);
    checkOutput("rst rsp_dst", {16'd0, rsp_dst}, 32'd0);
    checkOutput("rst op_count", {16'd0, op_count}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst no late rsp_valid", {30'd0, rsp_valid}, 32'd0);
    runVector(vecs[0]);

    // Counter wrap: preload op_count then complete one supported op
    @(negedge clk);
    force dut.r_opCount = 16'hFFFF;
    #1;
    release dut.r_opCount;
    expCount = 16'hFFFF;
    #1;
    checkOutput("wrap preload", {16'd0, op_count}, 32'hFFFF);
    runVector(vecs[7]);
    checkOutput("wrap op_count zero", {16'd0, op_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
